// File: rtl/seg_display_sched_if.sv
// seg_display_sched_if -- bundle between the display sources and the scheduler.
//   req              per-source display request (bit i = source i)
//   data0..data2     four hex nibbles per source, nibble 0 = rightmost digit
//   dot0..dot2       decimal-point digit index per source
//   gnt              one-hot grant, zero when idle
//   disp_data        registered data for the display driver
//   disp_dot         registered dot index for the display driver
//   busy             high while a grant is active
// master = source side (drives requests and data), slave = scheduler.
interface seg_display_sched_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [1:0]  dot0;
  logic [1:0]  dot1;
  logic [1:0]  dot2;
  logic [2:0]  gnt;
  logic [15:0] disp_data;
  logic [1:0]  disp_dot;
  logic        busy;

  modport master (
    output req, data0, data1, data2, dot0, dot1, dot2,
    input  gnt, disp_data, disp_dot, busy
  );

  modport slave (
    input  req, data0, data1, data2, dot0, dot1, dot2,
    output gnt, disp_data, disp_dot, busy
  );
endinterface

// File: rtl/seg_display_sched.sv
// seg_display_sched -- round-robin owner scheduler for a shared 4-digit
// seven-segment display with three requesting sources.
//   clk    system clock (rising edge)
//   rst_n  asynchronous active-low reset, release sampled on clk
//   bus    seg_display_sched_if.slave (req/data/dot in, gnt/disp/busy out)
// Parameters:
//   HOLD_CYCLES   minimum cycles an owner keeps the display while others wait
//   BLINK_CYCLES  half-period of the wait-blink
// Optional feature macro: SEG_SCHED_BLINK_EN -- blink the owner's digits
// while another source is waiting. Without it no blink counter is built.
//
// state | meaning
// IDLE  | no owner, display blank
// SHOW  | exactly one owner, its data/dot forwarded to the display
module seg_display_sched #(
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input logic              clk,
  input logic              rst_n,
  seg_display_sched_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);

  // Both counters are 26 bits wide; reject configurations that cannot fit.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 67108864 ||
      BLINK_CYCLES < 1 || BLINK_CYCLES > 33554432) begin : g_bad_cfg
    $error("seg_display_sched: HOLD_CYCLES/BLINK_CYCLES out of range");
  end

  state_t      state;
  logic        armed;
  logic [1:0]  last_owner;
  logic [25:0] hold_cnt;
  logic [2:0]  gnt_q;
  logic        busy_q;
  logic [15:0] data_q;
  logic [1:0]  dot_q;

  logic [2:0]  cand;
  logic [2:0]  rot;
  logic [2:0]  offs;
  logic [2:0]  sum;
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic        nxt_show;
  logic [1:0]  nxt_owner;
  logic        chg;
  logic [2:0]  nxt_gnt;
  logic [15:0] own_data;
  logic [1:0]  own_dot;
  logic        blank;
  logic [15:0] nxt_data;
  logic [1:0]  nxt_dot;

  // Round-robin pick: candidates are all requesters when idle, the waiting
  // non-owners when showing. Search starts at last_owner+1; rot re-orders the
  // candidates so that rot[0] is the first in search order.
  always_comb begin
    cand = (state == SHOW) ? (bus.req & ~gnt_q) : bus.req;
    case (last_owner)
      2'd0:    rot = {cand[0], cand[2], cand[1]};
      2'd1:    rot = {cand[1], cand[0], cand[2]};
      default: rot = cand;
    endcase
    pick_vld = |cand;
    if (rot[0])      offs = 3'd1;
    else if (rot[1]) offs = 3'd2;
    else             offs = 3'd3;
    sum      = {1'b0, last_owner} + offs;
    pick_idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  // Next owner. armed holds off the first grant until the second edge after
  // reset release.
  always_comb begin
    nxt_show  = 1'b0;
    nxt_owner = last_owner;
    chg       = 1'b0;
    if (armed) begin
      if (state == IDLE) begin
        if (pick_vld) begin
          nxt_show  = 1'b1;
          nxt_owner = pick_idx;
          chg       = 1'b1;
        end
      end else begin
        nxt_show = 1'b1;
        if ((bus.req & gnt_q) == 3'b000) begin
          if (pick_vld) begin
            nxt_owner = pick_idx;
            chg       = 1'b1;
          end else begin
            nxt_show = 1'b0;
          end
        end else if (pick_vld && hold_cnt == HOLD_LAST) begin
          nxt_owner = pick_idx;
          chg       = 1'b1;
        end
      end
    end
    nxt_gnt = nxt_show ? (3'b001 << nxt_owner) : 3'b000;
    case (nxt_owner)
      2'd0:    begin own_data = bus.data0; own_dot = bus.dot0; end
      2'd1:    begin own_data = bus.data1; own_dot = bus.dot1; end
      default: begin own_data = bus.data2; own_dot = bus.dot2; end
    endcase
  end

`ifdef SEG_SCHED_BLINK_EN
  localparam logic [25:0] BLINK_LAST = 26'(2 * BLINK_CYCLES - 1);
  localparam logic [25:0] BLINK_HALF = 26'(BLINK_CYCLES);

  logic [25:0] blink_cnt;
  logic [25:0] nxt_blink;

  // Counts a full on/off period from the grant; the second half is blank.
  always_comb begin
    if (!nxt_show || chg)          nxt_blink = 26'd0;
    else if (blink_cnt == BLINK_LAST) nxt_blink = 26'd0;
    else                           nxt_blink = blink_cnt + 26'd1;
    blank = nxt_show && ((bus.req & ~nxt_gnt) != 3'b000) && (nxt_blink >= BLINK_HALF);
  end
`else
  always_comb blank = 1'b0;
`endif

  always_comb begin
    nxt_data = (nxt_show && !blank) ? own_data : 16'hFFFF;
    nxt_dot  = nxt_show ? own_dot : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      last_owner <= 2'd2;
      hold_cnt   <= 26'd0;
      gnt_q      <= 3'b000;
      busy_q     <= 1'b0;
      data_q     <= 16'hFFFF;
      dot_q      <= 2'd0;
`ifdef SEG_SCHED_BLINK_EN
      blink_cnt  <= 26'd0;
`endif
    end else begin
      armed      <= 1'b1;
      state      <= nxt_show ? SHOW : IDLE;
      last_owner <= nxt_owner;
      gnt_q      <= nxt_gnt;
      busy_q     <= nxt_show;
      data_q     <= nxt_data;
      dot_q      <= nxt_dot;
      if (!nxt_show || chg)          hold_cnt <= 26'd0;
      else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 26'd1;
`ifdef SEG_SCHED_BLINK_EN
      blink_cnt  <= nxt_blink;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.disp_data = data_q;
  assign bus.disp_dot  = dot_q;

endmodule

// File: tb/tb_seg_display_sched.sv
module tb_seg_display_sched;
  localparam int HOLD  = 8;
  localparam int BLINK = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  req = 3'b000;
  logic [15:0] d [3];
  logic [1:0]  p [3];

  seg_display_sched_if bus ();
  assign bus.req   = req;
  assign bus.data0 = d[0];
  assign bus.data1 = d[1];
  assign bus.data2 = d[2];
  assign bus.dot0  = p[0];
  assign bus.dot1  = p[1];
  assign bus.dot2  = p[2];

  seg_display_sched #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index, cycles since the current grant.
  bit          m_armed;
  bit          m_show;
  int          m_owner;
  int          m_last;
  int          m_since;
  logic [2:0]  e_gnt;
  logic        e_busy;
  logic [15:0] e_data;
  logic [1:0]  e_dot;

  localparam logic [21:0] RESET_VEC = {3'b000, 1'b0, 16'hFFFF, 2'd0};

  function automatic int rr_pick(input logic [2:0] pend, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (pend[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [21:0] act_vec();
    return {bus.gnt, bus.busy, bus.disp_data, bus.disp_dot};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {e_gnt, e_busy, e_data, e_dot};
  endfunction

  task automatic model_reset();
    m_armed = 0; m_show = 0; m_owner = 0; m_last = 2; m_since = 0;
    e_gnt = 3'b000; e_busy = 1'b0; e_data = 16'hFFFF; e_dot = 2'd0;
  endtask

  task automatic model_step();
    logic [2:0] others;
    int w;
    if (!m_armed) begin
      m_armed = 1;
    end else if (!m_show) begin
      w = rr_pick(req, m_last);
      if (w >= 0) begin m_show = 1; m_owner = w; m_last = w; m_since = 0; end
    end else begin
      others = req & ~(3'b001 << m_owner);
      w = rr_pick(others, m_owner);
      if (((req >> m_owner) & 3'b001) == 3'b000) begin
        if (w >= 0) begin m_owner = w; m_last = w; m_since = 0; end
        else m_show = 0;
      end else if (w >= 0 && m_since >= HOLD - 1) begin
        m_owner = w; m_last = w; m_since = 0;
      end else begin
        m_since++;
      end
    end
    e_gnt  = m_show ? (3'b001 << m_owner) : 3'b000;
    e_busy = m_show;
    e_data = m_show ? d[m_owner] : 16'hFFFF;
    e_dot  = m_show ? p[m_owner] : 2'd0;
`ifdef SEG_SCHED_BLINK_EN
    if (m_show && (req & ~e_gnt) != 3'b000 && (m_since % (2 * BLINK)) >= BLINK)
      e_data = 16'hFFFF;
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin d[i] = 16'h0; p[i] = 2'd0; end
    req = 3'b000;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (act_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", act_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    d[0] = 16'h1234; p[0] = 2'd1;
    req = 3'b001;
    tick();
    n_tests++;
    if (bus.gnt !== 3'b000) begin
      n_fail++; $display("FAIL first_edge_no_grant: got %b want 000", bus.gnt);
    end
    tick();
    n_tests++;
    if ({bus.gnt, bus.disp_data, bus.disp_dot} !== {3'b001, 16'h1234, 2'd1}) begin
      n_fail++; $display("FAIL single_grant: got gnt=%b data=%h dot=%0d want 001 1234 1",
                         bus.gnt, bus.disp_data, bus.disp_dot);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec() || bus.gnt !== 3'b001) begin
        n_fail++; $display("FAIL single_hold: got %h want %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_rotation();
    logic [2:0] prev;
    logic [2:0] want_next;
    int run;
    int runs_checked;
    d[1] = 16'h5678; p[1] = 2'd2; d[2] = 16'h9ABC; p[2] = 2'd3;
    req = 3'b111;
    prev = bus.gnt; run = 0; runs_checked = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec() || bus.gnt == 3'b000) begin
        n_fail++; $display("FAIL rotation_model: got %h want %h", act_vec(), exp_vec());
      end
      if (bus.gnt == prev) run++;
      else begin
        want_next = {prev[1:0], prev[2]};
        n_tests++;
        if (bus.gnt !== want_next) begin
          n_fail++; $display("FAIL rotation_order: got %b want %b", bus.gnt, want_next);
        end
        if (i > 0 && runs_checked < 4) begin
          n_tests++;
          runs_checked++;
          if (run + 1 != HOLD) begin
            n_fail++; $display("FAIL rotation_hold_len: got %0d want %0d", run + 1, HOLD);
          end
        end
        prev = bus.gnt; run = 0;
      end
    end
  endtask

  task automatic test_drop();
    req = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL drop_setup: got %h want %h", act_vec(), exp_vec());
      end
    end
    req = 3'b000;
    tick();
    n_tests++;
    if (act_vec() !== RESET_VEC || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL drop_idle: got %h want %h", act_vec(), RESET_VEC);
    end
  endtask

  task automatic test_swap();
    int run;
    req = 3'b100;
    tick();
    n_tests++;
    if (bus.gnt !== 3'b100) begin
      n_fail++; $display("FAIL swap_grant2: got %b want 100", bus.gnt);
    end
    for (int i = 0; i < 3; i++) tick();
    req = 3'b001;
    tick();
    n_tests++;
    if (bus.gnt !== 3'b001 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL swap_to0: got %h want %h", act_vec(), exp_vec());
    end
    req = 3'b101;
    run = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL swap_model: got %h want %h", act_vec(), exp_vec());
      end
      if (bus.gnt == 3'b001 && run == i + 1) run++;
    end
    n_tests++;
    if (run != HOLD) begin
      n_fail++; $display("FAIL swap_counter_restart: got %0d want %0d", run, HOLD);
    end
  endtask

  task automatic test_reset_mid();
    req = 3'b010;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (bus.gnt !== 3'b010) begin
      n_fail++; $display("FAIL midrst_setup: got %b want 010", bus.gnt);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (act_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL midrst_values: got %h want %h", act_vec(), RESET_VEC);
    end
    req = 3'b011;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.gnt !== 3'b000) begin
      n_fail++; $display("FAIL midrst_first_edge: got %b want 000", bus.gnt);
    end
    tick();
    n_tests++;
    if (bus.gnt !== 3'b001 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL midrst_grant0: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_blink();
    logic [15:0] want;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    d[0] = 16'hAB00; p[0] = 2'd2;
    req = 3'b011;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < HOLD; k++) begin
      tick();
`ifdef SEG_SCHED_BLINK_EN
      want = ((k % (2 * BLINK)) < BLINK) ? 16'hAB00 : 16'hFFFF;
`else
      want = 16'hAB00;
`endif
      n_tests++;
      if (bus.disp_data !== want || bus.gnt !== 3'b001 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL blink_k%0d: got data=%h gnt=%b want data=%h gnt=001",
                           k, bus.disp_data, bus.gnt, want);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 3; s++) begin
        d[s] = 16'($urandom);
        p[s] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      tick();
      n_tests++;
      if (act_vec() !== exp_vec() || $countones(bus.gnt) > 1) begin
        n_fail++; $display("FAIL random_c%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_swap();
    test_reset_mid();
    test_blink();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
